piso_frame_scheduler: RTL

- Sequences the 12-bit parallel-in/serial-out shift register that serialises spectrogram bin magnitudes off-chip.
- Takes a frame of N_CH bin words from the feature datapath and snapshots it on a start pulse.
- Loads each enabled bin into the shifter in ascending channel order, holding it in shift mode for the remaining bits.
- Emits framing strobes that are bit-aligned with the shifter's serial output.

---
 rtl/piso_frame_scheduler.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/piso_frame_scheduler.sv
// piso_frame_scheduler
//   Sequences an external WIDTH-bit parallel-in/serial-out shifter so that a
//   frame of N_CH bin words leaves the chip LSB first, in ascending channel
//   order, skipping channels whose mask bit is clear.
//
//   Ports
//     clk         system clock, rising edge
//     rst         synchronous active-high reset
//     start       frame request, honoured only while idle
//     ch_data     N_CH packed words, channel i at [i*WIDTH +: WIDTH]
//     ch_mask     per-channel enable
//     piso_data   parallel word for the shifter
//     piso_sl     shifter control, 1 = load, 0 = shift
//     bit_valid   serial output of the shifter carries a frame bit
//     word_first  bit 0 of a word is on the serial output
//     frame_last  final bit of the frame is on the serial output
//     ch_idx      channel currently loaded or shifted
//     busy        frame in progress
//     done        one-cycle pulse at frame completion
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; snapshot taken on start
//   LOAD   | shifter parallel-loads snapshot word of ch_idx
//   SHIFT  | shifter shifts the remaining WIDTH-1 bits out
//   GAP    | idle spacing between words (only when GAP > 0)
//   DONE   | one-cycle completion pulse
module piso_frame_scheduler #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 12,
    parameter  int GAP   = 0,
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_CH*WIDTH-1:0] ch_data,
    input  logic [N_CH-1:0]       ch_mask,
    output logic [WIDTH-1:0]      piso_data,
    output logic                  piso_sl,
    output logic                  bit_valid,
    output logic                  word_first,
    output logic                  frame_last,
    output logic [CW-1:0]         ch_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [N_CH*WIDTH-1:0] snap_data, snap_data_nxt;
    logic [N_CH-1:0]       snap_mask, snap_mask_nxt;
    logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
    logic [3:0]            gap_cnt, gap_cnt_nxt;
    logic [CW-1:0]         ch_nxt;
    logic [WIDTH-1:0]      word_nxt;

    logic [CW-1:0]         first_idx;
    logic                  first_hit;
    logic [CW-1:0]         next_idx;
    logic                  has_next;
    logic                  last_bit;
    logic                  frame_end;

    // Lowest enabled channel of the incoming mask, and the lowest enabled
    // snapshot channel above the current one. Descending loops so the
    // lowest match is the one that sticks.
    always_comb begin
        first_idx = '0;
        first_hit = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_idx = CW'(i);
                first_hit = 1'b1;
            end
        end
        next_idx = '0;
        has_next = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (snap_mask[i] && (i > int'(ch_idx))) begin
                next_idx = CW'(i);
                has_next = 1'b1;
            end
        end
    end

    assign last_bit  = (bit_cnt == BW'(WIDTH - 1));
    assign frame_end = (state == S_SHIFT) && last_bit && !has_next;

    always_comb begin
        state_nxt     = state;
        snap_data_nxt = snap_data;
        snap_mask_nxt = snap_mask;
        bit_cnt_nxt   = bit_cnt;
        gap_cnt_nxt   = gap_cnt;
        ch_nxt        = ch_idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    snap_data_nxt = ch_data;
                    snap_mask_nxt = ch_mask;
                    if (first_hit) begin
                        ch_nxt    = first_idx;
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                bit_cnt_nxt = BW'(1);
                state_nxt   = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_bit) begin
                    bit_cnt_nxt = '0;
                    if (has_next) begin
                        if (GAP > 0) begin
                            gap_cnt_nxt = 4'(GAP - 1);
                            state_nxt   = S_GAP;
                        end else begin
                            ch_nxt    = next_idx;
                            state_nxt = S_LOAD;
                        end
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + BW'(1);
                end
            end
            S_GAP: begin
                // ch_idx stays put during the gap so has_next/next_idx
                // still refer to the word just sent.
                if (gap_cnt == 4'd0) begin
                    ch_nxt    = next_idx;
                    state_nxt = S_LOAD;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Word to present when entering LOAD, taken from the snapshot as it
    // will be after this edge (covers the IDLE->LOAD capture cycle).
    always_comb begin
        word_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (CW'(i) == ch_nxt) begin
                word_nxt = snap_data_nxt[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            snap_data  <= '0;
            snap_mask  <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ch_idx     <= '0;
            piso_sl    <= 1'b0;
            piso_data  <= '0;
            bit_valid  <= 1'b0;
            word_first <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            snap_data  <= snap_data_nxt;
            snap_mask  <= snap_mask_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            ch_idx     <= ch_nxt;
            piso_sl    <= (state_nxt == S_LOAD);
            if (state_nxt == S_LOAD) begin
                piso_data <= word_nxt;
            end
            // Serial-side flags trail the LOAD/SHIFT cycle by one register,
            // matching the shifter's registered serial output.
            bit_valid  <= (state == S_LOAD) || (state == S_SHIFT);
            word_first <= (state == S_LOAD);
            frame_last <= frame_end;
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
        end
    end

endmodule
